// File: rtl/dom_session_ctrl.sv
// rtl/dom_session_ctrl.sv - session sequencer for the DOM-protected ASCON datapath
module dom_session_ctrl #(
    parameter int WARMUP_CYCLES  = 18,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        req,
    input  logic        abort,
    input  logic [1:0]  mode_in,
    input  logic [79:0] iv_base,
    input  logic        tv,
    output logic        dom_start,
    output logic        dom_en,
    output logic        asc_start,
    output logic [1:0]  asc_mode,
    output logic [79:0] iv_mask_0,
    output logic [79:0] iv_mask_1,
    output logic [79:0] iv_mask_2,
    output logic [79:0] iv_mask_3,
    output logic [79:0] iv_mask_4,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [12:0] sess_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_SEED, S_WARM, S_RUN, S_DONE} state_t;

    localparam logic [7:0]  WARM_LAST  = 8'(WARMUP_CYCLES - 1);
    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYCLES - 1);
    localparam bit          TO_ENABLED = (TIMEOUT_CYCLES != 0);

    state_t      state_q, state_d;
    logic [7:0]  warm_cnt_q, warm_cnt_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic [1:0]  mode_q, mode_d;
    logic [79:0] iv_q [5];
    logic [79:0] iv_d [5];
    logic [12:0] sess_cnt_q, sess_cnt_d;
    logic        err_q, err_d;
    logic        dom_start_q, dom_start_d;
    logic        dom_en_q, dom_en_d;
    logic        asc_start_q, asc_start_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        to_cnt_d   = to_cnt_q;
        mode_d     = mode_q;
        iv_d       = iv_q;
        sess_cnt_d = sess_cnt_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_SEED;
                    mode_d  = mode_in;
                    err_d   = 1'b0;
                    // Lane index and session number make each lane's IV unique per session.
                    for (int k = 0; k < 5; k++) begin
                        iv_d[k] = iv_base ^ {64'b0, sess_cnt_q, 3'(k)};
                    end
                end
            end
            S_SEED: begin
                state_d    = S_WARM;
                warm_cnt_d = 8'd0;
            end
            S_WARM: begin
                if (warm_cnt_q == WARM_LAST) begin
                    state_d  = S_RUN;
                    to_cnt_d = 16'd0;
                end else begin
                    warm_cnt_d = warm_cnt_q + 8'd1;
                end
            end
            S_RUN: begin
                if (tv) begin
                    state_d    = S_DONE;
                    sess_cnt_d = sess_cnt_q + 13'd1;
                end else if (TO_ENABLED && (to_cnt_q == TO_LAST)) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort discards everything the current cycle would have latched, including a request in IDLE.
        if (abort) begin
            state_d    = S_IDLE;
            err_d      = 1'b0;
            mode_d     = mode_q;
            iv_d       = iv_q;
            sess_cnt_d = sess_cnt_q;
        end

        dom_start_d = (state_d == S_SEED);
        dom_en_d    = (state_d == S_WARM) || (state_d == S_RUN);
        asc_start_d = (state_d == S_RUN) && (state_q != S_RUN);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q     <= S_IDLE;
            warm_cnt_q  <= 8'd0;
            to_cnt_q    <= 16'd0;
            mode_q      <= 2'd0;
            for (int k = 0; k < 5; k++) begin
                iv_q[k] <= 80'd0;
            end
            sess_cnt_q  <= 13'd0;
            err_q       <= 1'b0;
            dom_start_q <= 1'b0;
            dom_en_q    <= 1'b0;
            asc_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            to_cnt_q    <= to_cnt_d;
            mode_q      <= mode_d;
            iv_q        <= iv_d;
            sess_cnt_q  <= sess_cnt_d;
            err_q       <= err_d;
            dom_start_q <= dom_start_d;
            dom_en_q    <= dom_en_d;
            asc_start_q <= asc_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign dom_start = dom_start_q;
    assign dom_en    = dom_en_q;
    assign asc_start = asc_start_q;
    assign asc_mode  = mode_q;
    assign iv_mask_0 = iv_q[0];
    assign iv_mask_1 = iv_q[1];
    assign iv_mask_2 = iv_q[2];
    assign iv_mask_3 = iv_q[3];
    assign iv_mask_4 = iv_q[4];
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign sess_cnt  = sess_cnt_q;

endmodule

// File: tb/tb_dom_session_ctrl.sv
// tb/tb_dom_session_ctrl.sv - self-checking bench for dom_session_ctrl
module tb_dom_session_ctrl;

    localparam int W = 18;
    localparam int T = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nRST, req, abort, tv;
    logic [1:0]  mode_in;
    logic [79:0] iv_base;
    logic        dom_start, dom_en, asc_start, busy, done, err;
    logic [1:0]  asc_mode;
    logic [79:0] m0, m1, m2, m3, m4;
    logic [12:0] sess_cnt;
    logic [79:0] masks [5];
    assign masks[0] = m0;
    assign masks[1] = m1;
    assign masks[2] = m2;
    assign masks[3] = m3;
    assign masks[4] = m4;

    logic        nRST_b, req_b, abort_b, tv_b;
    logic [1:0]  mode_in_b;
    logic [79:0] iv_base_b;
    logic        dom_start_b, dom_en_b, asc_start_b, busy_b, done_b, err_b;
    logic [1:0]  asc_mode_b;
    logic [79:0] b0, b1, b2, b3, b4;
    logic [12:0] sess_cnt_b;

    dom_session_ctrl #(.WARMUP_CYCLES(W), .TIMEOUT_CYCLES(T)) dut_a (
        .clk(clk), .nRST(nRST), .req(req), .abort(abort), .mode_in(mode_in),
        .iv_base(iv_base), .tv(tv), .dom_start(dom_start), .dom_en(dom_en),
        .asc_start(asc_start), .asc_mode(asc_mode), .iv_mask_0(m0), .iv_mask_1(m1),
        .iv_mask_2(m2), .iv_mask_3(m3), .iv_mask_4(m4), .busy(busy), .done(done),
        .err(err), .sess_cnt(sess_cnt)
    );

    dom_session_ctrl #(.WARMUP_CYCLES(1), .TIMEOUT_CYCLES(0)) dut_b (
        .clk(clk), .nRST(nRST_b), .req(req_b), .abort(abort_b), .mode_in(mode_in_b),
        .iv_base(iv_base_b), .tv(tv_b), .dom_start(dom_start_b), .dom_en(dom_en_b),
        .asc_start(asc_start_b), .asc_mode(asc_mode_b), .iv_mask_0(b0), .iv_mask_1(b1),
        .iv_mask_2(b2), .iv_mask_3(b3), .iv_mask_4(b4), .busy(busy_b), .done(done_b),
        .err(err_b), .sess_cnt(sess_cnt_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: session-level facts only.
    int          exp_sess = 0;
    bit          exp_err  = 1'b0;
    logic [1:0]  exp_mode = 2'd0;
    logic [79:0] exp_ivb  = 80'd0;
    int          base_cnt = 0;
    bit          loaded   = 1'b0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [79:0] exp_mask(input int j);
        logic [79:0] salt;
        salt = (80'(base_cnt) << 3) | 80'(j);
        return loaded ? (exp_ivb ^ salt) : 80'd0;
    endfunction

    task automatic check_all(input string tag, input bit e_busy, input bit e_ds, input bit e_en,
                             input bit e_as, input bit e_done, input bit e_err, input int e_cnt);
        chk({tag, ".busy"}, busy, e_busy);
        chk({tag, ".dom_start"}, dom_start, e_ds);
        chk({tag, ".dom_en"}, dom_en, e_en);
        chk({tag, ".asc_start"}, asc_start, e_as);
        chk({tag, ".done"}, done, e_done);
        chk({tag, ".err"}, err, e_err);
        chk({tag, ".sess_cnt"}, sess_cnt, 80'(e_cnt % 8192));
        chk({tag, ".asc_mode"}, asc_mode, exp_mode);
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("%s.iv_mask_%0d", tag, j), masks[j], exp_mask(j));
        end
    endtask

    task automatic idle_cycles(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            tv    = 1'($urandom_range(0, 1));
            abort = noise && ($urandom_range(0, 3) == 0);
            tick();
            if (abort) exp_err = 1'b0;
            abort = 1'b0;
            tv    = 1'b0;
            check_all("idle", 0, 0, 0, 0, 0, exp_err, exp_sess);
        end
    endtask

    // d: RUN cycles before tv (d >= T means timeout); ea: edge of abort after accept, 0 = none.
    task automatic session(input logic [79:0] ivb, input logic [1:0] md, input int d, input int ea);
        int e_t, e_to, e_end, kind, last;
        e_t  = W + 2 + d;
        e_to = W + 1 + T;
        if (d < T) begin kind = 0; e_end = e_t; end
        else begin kind = 1; e_end = e_to; end
        if (ea > 0 && ea <= e_end) begin kind = 2; e_end = ea; end
        last = e_end + ((kind == 0) ? 1 : 0);

        req = 1'b1; iv_base = ivb; mode_in = md;
        tick();
        req = 1'b0;
        exp_err = 1'b0; exp_mode = md; exp_ivb = ivb; base_cnt = exp_sess; loaded = 1'b1;

        for (int k = 0; k <= last; k++) begin
            if (k < e_end)
                check_all("sess", 1, k == 0, k >= 1, k == W + 1, 0, 0, base_cnt);
            else if (k == e_end && kind == 0)
                check_all("done", 1, 0, 0, 0, 1, 0, base_cnt + 1);
            else if (k == e_end && kind == 1)
                check_all("timeout", 0, 0, 0, 0, 0, 1, base_cnt);
            else if (k == e_end)
                check_all("abort", 0, 0, 0, 0, 0, 0, base_cnt);
            else
                check_all("post", 0, 0, 0, 0, 0, 0, base_cnt + 1);
            if (k < last) begin
                if (k >= W + 1 && k < e_end) tv = (k + 1 == e_t);
                else tv = 1'($urandom_range(0, 1));
                abort   = (kind == 2) && (k + 1 == ea);
                req     = (k < e_end) && ($urandom_range(0, 3) == 0);
                mode_in = 2'($urandom);
                iv_base = {16'($urandom), $urandom, $urandom};
                tick();
                tv = 1'b0; abort = 1'b0; req = 1'b0;
            end
        end
        if (kind == 0) exp_sess = (exp_sess + 1) % 8192;
        if (kind == 1) exp_err = 1'b1;
    endtask

    initial begin
        int ndone;
        nRST = 1'b0; req = 1'b0; abort = 1'b0; tv = 1'b0; mode_in = 2'd0; iv_base = 80'd0;
        nRST_b = 1'b0; req_b = 1'b0; abort_b = 1'b0; tv_b = 1'b0; mode_in_b = 2'd0; iv_base_b = 80'd0;
        tick();
        tick();
        check_all("reset", 0, 0, 0, 0, 0, 0, 0);
        nRST = 1'b1; nRST_b = 1'b1;
        idle_cycles(2, 0);

        session(80'h0, 2'b01, 9, 0);
        chk("tp1.iv_mask_3", m3, 80'h3);
        chk("tp1.sess_cnt", sess_cnt, 80'd1);

        session(80'hFFFF, 2'b10, 4, 0);
        chk("tp2.iv_mask_2", m2, 80'hFFF5);

        session({$urandom, $urandom, 16'($urandom)}, 2'b11, T + 4, 0);
        idle_cycles(3, 0);

        session(80'h1234, 2'b00, 2, 6);
        idle_cycles(1, 0);
        session(80'h5678, 2'b01, 5, 0);

        session(80'h9ABC, 2'b10, 3, W + 5);
        idle_cycles(1, 0);

        req = 1'b1; abort = 1'b1; mode_in = ~exp_mode; iv_base = ~exp_ivb;
        tick();
        req = 1'b0; abort = 1'b0; exp_err = 1'b0;
        check_all("abort_req_idle", 0, 0, 0, 0, 0, 0, exp_sess);

        for (int s = 0; s < 40; s++) begin
            int d, ea;
            d  = $urandom_range(0, T + 3);
            ea = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W + 2 + T) : 0;
            session({16'($urandom), $urandom, $urandom}, 2'($urandom), d, ea);
            idle_cycles($urandom_range(0, 3), 1);
        end

        req_b = 1'b1; tv_b = 1'b1;
        ndone = 0;
        for (int c = 0; c < 45000 && ndone < 8192; c++) begin
            tick();
            if (done_b) begin
                ndone++;
                chk("wrap.sess_cnt", sess_cnt_b, 80'(ndone % 8192));
            end
        end
        req_b = 1'b0; tv_b = 1'b0;
        chk("wrap.sessions", 80'(ndone), 80'd8192);
        tick(); tick(); tick();
        chk("wrap.final_cnt", sess_cnt_b, 80'd0);
        chk("wrap.idle", busy_b, 1'b0);

        req = 1'b1; iv_base = 80'hABCDE; mode_in = 2'b11;
        tick();
        req = 1'b0;
        for (int i = 0; i < W + 3; i++) tick();
        chk("rst_mid.in_run", dom_en, 1'b1);
        nRST = 1'b0;
        #1;
        exp_sess = 0; exp_err = 1'b0; exp_mode = 2'd0; loaded = 1'b0;
        check_all("rst_mid", 0, 0, 0, 0, 0, 0, 0);
        tick();
        nRST = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
